// File: rtl/isp_dgain_pkg.sv
// Shared definitions for the raw-domain Bayer stages: channel encoding,
// CFA pattern codes and the width of the rounded gain product.
package isp_dgain_pkg;

    typedef enum logic [1:0] {
        CH_R  = 2'd0,
        CH_GR = 2'd1,
        CH_GB = 2'd2,
        CH_B  = 2'd3
    } channel_t;

    localparam logic [1:0] BAYER_RGGB = 2'd0;
    localparam logic [1:0] BAYER_GRBG = 2'd1;
    localparam logic [1:0] BAYER_GBRG = 2'd2;
    localparam logic [1:0] BAYER_BGGR = 2'd3;

    // Width left after adding the half-LSB (one guard bit) and dropping the fraction.
    function automatic int rnd_width(input int bits, input int gw, input int gf);
        return bits + gw + 1 - gf;
    endfunction

endpackage

// File: rtl/isp_bayer_pos.sv
// Bayer position tracker: column/row parity of the current pixel plus the
// frame-boundary (vsync rising edge) strobe.
module isp_bayer_pos (
    input  logic pclk,
    input  logic rst_n,
    input  logic href,
    input  logic vsync,
    output logic x_par,
    output logic y_par,
    output logic vsync_rise
);

    logic href_prev;
    logic vsync_prev;
    logic x_q;
    logic href_rise;
    logic href_fall;

    assign href_rise  = href & ~href_prev;
    assign href_fall  = ~href & href_prev;
    assign vsync_rise = vsync & ~vsync_prev;

    // The first pixel of every line is column 0 even if href was never low long enough.
    assign x_par = href_rise ? 1'b0 : x_q;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            href_prev  <= 1'b0;
            vsync_prev <= 1'b0;
            x_q        <= 1'b0;
            y_par      <= 1'b0;
        end else begin
            href_prev  <= href;
            vsync_prev <= vsync;
            x_q        <= href ? ~x_par : 1'b0;
            if (vsync_rise)
                y_par <= 1'b0;
            else if (href_fall)
                y_par <= ~y_par;
        end
    end

endmodule

// File: rtl/isp_bayer_dgain.sv
// Per-channel fractional digital gain with frame-synchronous gain shadowing,
// round-half-up/saturate output and a per-frame clipped-pixel count.
module isp_bayer_dgain
    import isp_dgain_pkg::*;
#(
    parameter int BITS           = 12,
    parameter int WIDTH          = 1280,
    parameter int HEIGHT         = 960,
    parameter int GAIN_INT_BITS  = 4,
    parameter int GAIN_FRAC_BITS = 8,
    parameter int GW             = GAIN_INT_BITS + GAIN_FRAC_BITS,
    parameter int CNT_BITS       = $clog2(WIDTH * HEIGHT + 1)
) (
    input  logic                pclk,
    input  logic                rst_n,
    input  logic                isManual,
    input  logic [1:0]          bayer,
    input  logic [4*GW-1:0]     manual_gain,
    input  logic [4*GW-1:0]     ae_gain,
    input  logic                in_href,
    input  logic                in_vsync,
    input  logic [BITS-1:0]     in_raw,
    output logic                out_href,
    output logic                out_vsync,
    output logic [BITS-1:0]     out_raw,
    output logic                applied_ae,
    output logic [CNT_BITS-1:0] clip_count
);

    localparam int PW = BITS + GW;
    localparam int RW = rnd_width(BITS, GW, GAIN_FRAC_BITS);
    localparam logic [PW:0] HALF = (PW + 1)'(1) << (GAIN_FRAC_BITS - 1);

    function automatic logic [RW-1:0] round_half_up(input logic [PW-1:0] p);
        logic [PW:0] sum;
        sum = {1'b0, p} + HALF;
        return RW'(sum >> GAIN_FRAC_BITS);
    endfunction

    function automatic logic saturates(input logic [RW-1:0] r);
        return |r[RW-1:BITS];
    endfunction

    function automatic logic [BITS-1:0] saturate(input logic [RW-1:0] r);
        return saturates(r) ? '1 : r[BITS-1:0];
    endfunction

    logic              x_par;
    logic              y_par;
    logic              vsync_rise;
    logic              seen_first_vsync;
    logic              use_ae;
    logic [4*GW-1:0]   load_set;
    logic [1:0]        bayer_active;
    logic [GW-1:0]     gain_active [4];
    channel_t          ch_in;

    logic [BITS-1:0]   raw_p0;
    channel_t          ch_p0;
    logic              vld_p0;
    logic              vs_p0;
    logic [PW-1:0]     prod_p1;
    logic              vld_p1;
    logic              vs_p1;
    logic [RW-1:0]     rnd_p2;
    logic              clip_p2;
    logic [CNT_BITS-1:0] run_count;

    isp_bayer_pos u_pos (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .href       (in_href),
        .vsync      (in_vsync),
        .x_par      (x_par),
        .y_par      (y_par),
        .vsync_rise (vsync_rise)
    );

    // AE gains become eligible only once a full frame boundary has been seen.
    assign use_ae   = ~isManual & seen_first_vsync;
    assign load_set = use_ae ? ae_gain : manual_gain;
    assign ch_in    = channel_t'(bayer_active ^ {y_par, x_par});

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            seen_first_vsync <= 1'b0;
            applied_ae       <= 1'b0;
            bayer_active     <= 2'd0;
            for (int i = 0; i < 4; i++)
                gain_active[i] <= '0;
        end else if (vsync_rise) begin
            seen_first_vsync <= 1'b1;
            applied_ae       <= use_ae;
            bayer_active     <= bayer;
            for (int i = 0; i < 4; i++)
                gain_active[i] <= load_set[i*GW +: GW];
        end
    end

    // S0: register pixel, channel and syncs
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            raw_p0 <= '0;
            ch_p0  <= CH_R;
            vld_p0 <= 1'b0;
            vs_p0  <= 1'b0;
        end else begin
            raw_p0 <= in_raw;
            ch_p0  <= ch_in;
            vld_p0 <= in_href;
            vs_p0  <= in_vsync;
        end
    end

    // S1: multiply by the channel gain
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            prod_p1 <= '0;
            vld_p1  <= 1'b0;
            vs_p1   <= 1'b0;
        end else begin
            prod_p1 <= PW'(raw_p0) * PW'(gain_active[ch_p0]);
            vld_p1  <= vld_p0;
            vs_p1   <= vs_p0;
        end
    end

    // S2: round, saturate and count clipped pixels
    assign rnd_p2  = round_half_up(prod_p1);
    assign clip_p2 = vld_p1 & saturates(rnd_p2);

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            out_raw   <= '0;
            out_href  <= 1'b0;
            out_vsync <= 1'b0;
        end else begin
            out_raw   <= vld_p1 ? saturate(rnd_p2) : '0;
            out_href  <= vld_p1;
            out_vsync <= vs_p1;
        end
    end

    // A clip landing on the frame-boundary cycle is dropped rather than carried over.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            run_count  <= '0;
            clip_count <= '0;
        end else if (vsync_rise) begin
            clip_count <= run_count;
            run_count  <= '0;
        end else if (clip_p2 && run_count != '1) begin
            run_count <= run_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_isp_bayer_dgain.sv
// Directed bench for isp_bayer_dgain: vector table for the gain arithmetic plus
// sequences for latency, Bayer patterns, frame shadowing, clip count, reset and AE handover.
module tb_isp_bayer_dgain;
    import isp_dgain_pkg::*;

    localparam int BITS     = 12;
    localparam int GW       = 12;
    localparam int CNT_BITS = $clog2(1280 * 960 + 1);

    logic                pclk = 1'b0;
    logic                rst_n = 1'b0;
    logic                isManual = 1'b1;
    logic [1:0]          bayer = 2'd0;
    logic [4*GW-1:0]     manual_gain = '0;
    logic [4*GW-1:0]     ae_gain = '0;
    logic                in_href = 1'b0;
    logic                in_vsync = 1'b0;
    logic [BITS-1:0]     in_raw = '0;
    logic                out_href;
    logic                out_vsync;
    logic [BITS-1:0]     out_raw;
    logic                applied_ae;
    logic [CNT_BITS-1:0] clip_count;

    isp_bayer_dgain dut (
        .pclk        (pclk),
        .rst_n       (rst_n),
        .isManual    (isManual),
        .bayer       (bayer),
        .manual_gain (manual_gain),
        .ae_gain     (ae_gain),
        .in_href     (in_href),
        .in_vsync    (in_vsync),
        .in_raw      (in_raw),
        .out_href    (out_href),
        .out_vsync   (out_vsync),
        .out_raw     (out_raw),
        .applied_ae  (applied_ae),
        .clip_count  (clip_count)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;
    logic [BITS-1:0] cap [$];

    always @(negedge pclk) if (out_href) cap.push_back(out_raw);

    typedef struct {
        logic [11:0] raw;
        logic [11:0] gain;
        logic [11:0] exp;
        logic        clip;
    } vec_t;

    vec_t vecs [16];
    int   bayer_exp [3][4];
    logic [1:0] bayer_pat [3];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic expect_px(input string name, input int exp);
        if (cap.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no output pixel, expected %0d", name, exp);
        end else begin
            check(name, cap.pop_front(), exp);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    task automatic vsync_pulse();
        in_vsync = 1'b1;
        step();
        in_vsync = 1'b0;
        step();
        step();
    endtask

    task automatic send_line(input int n, input logic [BITS-1:0] v);
        in_href = 1'b1;
        in_raw  = v;
        repeat (n) step();
        in_href = 1'b0;
        in_raw  = '0;
        repeat (5) step();
    endtask

    function automatic logic [4*GW-1:0] pack(input logic [11:0] b, input logic [11:0] gb,
                                             input logic [11:0] gr, input logic [11:0] r);
        return {b, gb, gr, r};
    endfunction

    initial begin
        logic prev_clip;

        vecs[0]  = '{12'd1000, 12'h100, 12'd1000, 1'b0};
        vecs[1]  = '{12'd1000, 12'h200, 12'd2000, 1'b0};
        vecs[2]  = '{12'd1000, 12'h080, 12'd500,  1'b0};
        vecs[3]  = '{12'd3,    12'h180, 12'd5,    1'b0};
        vecs[4]  = '{12'd4095, 12'h101, 12'd4095, 1'b1};
        vecs[5]  = '{12'd4095, 12'h100, 12'd4095, 1'b0};
        vecs[6]  = '{12'd1,    12'h080, 12'd1,    1'b0};
        vecs[7]  = '{12'd1,    12'h07F, 12'd0,    1'b0};
        vecs[8]  = '{12'd4095, 12'hFFF, 12'd4095, 1'b1};
        vecs[9]  = '{12'd2049, 12'h200, 12'd4095, 1'b1};
        vecs[10] = '{12'd2047, 12'h200, 12'd4094, 1'b0};
        vecs[11] = '{12'd5,    12'h133, 12'd6,    1'b0};
        vecs[12] = '{12'd100,  12'h000, 12'd0,    1'b0};
        vecs[13] = '{12'd0,    12'hFFF, 12'd0,    1'b0};
        vecs[14] = '{12'd2,    12'h0C0, 12'd2,    1'b0};
        vecs[15] = '{12'd7,    12'h024, 12'd1,    1'b0};

        bayer_pat[0] = BAYER_BGGR; bayer_exp[0] = '{400, 300, 200, 100};
        bayer_pat[1] = BAYER_GRBG; bayer_exp[1] = '{200, 100, 400, 300};
        bayer_pat[2] = BAYER_GBRG; bayer_exp[2] = '{300, 400, 100, 200};

        // power-up reset
        repeat (3) step();
        check("rst_out_href", out_href, 0);
        check("rst_out_vsync", out_vsync, 0);
        check("rst_out_raw", out_raw, 0);
        check("rst_applied_ae", applied_ae, 0);
        check("rst_clip_count", clip_count, 0);
        rst_n = 1'b1;
        step();

        // manual gains, RGGB, latency
        isManual    = 1'b1;
        bayer       = BAYER_RGGB;
        manual_gain = pack(12'h080, 12'h100, 12'h100, 12'h200);
        vsync_pulse();
        check("first_applied_ae", applied_ae, 0);
        in_href = 1'b1;
        in_raw  = 12'd1000;
        step();
        check("lat_cycle1_href", out_href, 0);
        step();
        check("lat_cycle2_href", out_href, 0);
        step();
        check("lat_cycle3_href", out_href, 1);
        check("lat_cycle3_raw", out_raw, 2000);
        step();
        in_href = 1'b0;
        in_raw  = '0;
        repeat (5) step();
        check("idle_raw_zero", out_raw, 0);
        send_line(4, 12'd1000);
        expect_px("line0_R", 2000);
        expect_px("line0_Gr", 1000);
        expect_px("line0_R2", 2000);
        expect_px("line0_Gr2", 1000);
        expect_px("line1_Gb", 1000);
        expect_px("line1_B", 500);
        expect_px("line1_Gb2", 1000);
        expect_px("line1_B2", 500);
        check("manual_leftover", cap.size(), 0);
        cap.delete();

        // arithmetic vectors, one single-pixel frame each
        prev_clip = 1'b0;
        for (int i = 0; i < 16; i++) begin
            manual_gain = {4{vecs[i].gain}};
            vsync_pulse();
            check($sformatf("vec%0d_clip_prev", i), clip_count, prev_clip);
            send_line(1, vecs[i].raw);
            expect_px($sformatf("vec%0d_raw%0d_gain%0h", i, vecs[i].raw, vecs[i].gain), vecs[i].exp);
            prev_clip = vecs[i].clip;
        end
        cap.delete();

        // Bayer patterns with distinct per-channel gains
        manual_gain = pack(12'h400, 12'h300, 12'h200, 12'h100);
        for (int p = 0; p < 3; p++) begin
            bayer = bayer_pat[p];
            vsync_pulse();
            send_line(2, 12'd100);
            send_line(2, 12'd100);
            for (int k = 0; k < 4; k++)
                expect_px($sformatf("bayer%0d_px%0d", bayer_pat[p], k), bayer_exp[p][k]);
        end
        cap.delete();

        // mid-frame manual gain change is shadowed until the next frame
        bayer       = BAYER_RGGB;
        manual_gain = {4{12'h100}};
        vsync_pulse();
        for (int l = 0; l < 5; l++) send_line(2, 12'd1000);
        in_href = 1'b1;
        in_raw  = 12'd1000;
        step();
        step();
        manual_gain = {4{12'h200}};
        step();
        step();
        in_href = 1'b0;
        in_raw  = '0;
        repeat (5) step();
        for (int k = 0; k < 14; k++) expect_px($sformatf("midframe_px%0d", k), 1000);
        vsync_pulse();
        send_line(2, 12'd1000);
        expect_px("newframe_px0", 2000);
        expect_px("newframe_px1", 2000);
        cap.delete();

        // clip count of 7 through the AE path
        isManual = 1'b0;
        ae_gain  = {4{12'h101}};
        vsync_pulse();
        check("clip_frame_applied_ae", applied_ae, 1);
        check("clip_count_before", clip_count, 0);
        in_href = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_raw = (k < 7) ? 12'd4095 : 12'd100;
            step();
        end
        in_href = 1'b0;
        in_raw  = '0;
        repeat (5) step();
        vsync_pulse();
        check("clip_count_7", clip_count, 7);
        cap.delete();

        // reset asserted mid-line
        in_href = 1'b1;
        in_raw  = 12'd4095;
        repeat (6) step();
        check("pre_reset_href", out_href, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_href", out_href, 0);
        check("midrst_out_raw", out_raw, 0);
        check("midrst_out_vsync", out_vsync, 0);
        check("midrst_applied_ae", applied_ae, 0);
        check("midrst_clip_count", clip_count, 0);
        step();
        in_href = 1'b0;
        in_raw  = '0;
        step();
        rst_n = 1'b1;
        step();
        cap.delete();
        send_line(4, 12'd4095);
        for (int k = 0; k < 4; k++) expect_px($sformatf("postrst_zero_gain_px%0d", k), 0);
        check("postrst_clip_count", clip_count, 0);

        // AE handover after reset: manual first frame, AE from second boundary
        manual_gain = {4{12'h100}};
        ae_gain     = {4{12'h200}};
        isManual    = 1'b0;
        vsync_pulse();
        check("ae_frame1_applied_ae", applied_ae, 0);
        check("ae_frame1_clip_count", clip_count, 0);
        send_line(2, 12'd1000);
        expect_px("ae_frame1_px0", 1000);
        expect_px("ae_frame1_px1", 1000);
        vsync_pulse();
        check("ae_frame2_applied_ae", applied_ae, 1);
        send_line(2, 12'd1000);
        expect_px("ae_frame2_px0", 2000);
        expect_px("ae_frame2_px1", 2000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
